// File: rtl/conv_pkg.sv
// Shared constants and the requantise/saturate helper for the convolution
// output path.
package conv_pkg;

  // Accumulator width produced by the 8x4 convolution core.
  localparam int ACC_SIZE      = 18;
  // Default width of the requantised output samples.
  localparam int OUT_WIDTH     = 8;
  // Default requantisation shift.
  localparam int DEFAULT_SHIFT = 4;
  // Working width of sat_requant; wide enough for any accumulator we build.
  localparam int RQ_W          = 64;

  // Arithmetic right shift (floor), optional ReLU, then clip to a signed
  // out_w-bit range. Returns {sat_flag, value}; value is RQ_W bits and the
  // caller keeps the low out_w bits. A ReLU clamp alone never sets sat_flag.
  function automatic logic [RQ_W:0] sat_requant(
    input logic signed [RQ_W-1:0] in_val,
    input int                     shift,
    input logic                   relu,
    input int                     out_w = OUT_WIDTH
  );
    logic signed [RQ_W-1:0] t;
    logic signed [RQ_W-1:0] max_v;
    logic signed [RQ_W-1:0] min_v;
    logic                   sat;
    t     = in_val >>> shift;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    sat   = 1'b0;
    if (relu && t[RQ_W-1]) begin
      t = '0;
    end
    if (t > max_v) begin
      t   = max_v;
      sat = 1'b1;
    end else if (t < min_v) begin
      t   = min_v;
      sat = 1'b1;
    end
    return {sat, t};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO: power-of-two depth, registered count, read data
// forced to zero while empty so the output bus never shows stale entries.
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [PW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PW:0] COUNT_FULL = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == COUNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Guard requests so a full push or an empty pop can never corrupt state.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because reads are masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/conv_out_postproc.sv
// Output post-processing for the convolution core: requantise each 18-bit
// accumulator sample (shift, optional ReLU, saturate), buffer the results in
// a small FIFO and count how many accepted samples were clipped.
//
// Handshake: on both ports a transfer happens on the rising edge where valid
// and ready are both high. Valid, once raised, holds with stable data until
// the transfer. s_ready_y comes only from the registered FIFO occupancy (and
// is low during reset); it never looks at m_ready_z, so a full FIFO accepts
// again only in the cycle after a pop.
module conv_out_postproc
  import conv_pkg::*;
#(
  parameter int IN_WIDTH  = ACC_SIZE,
  parameter int OUT_WIDTH = conv_pkg::OUT_WIDTH,
  parameter int SHIFT     = DEFAULT_SHIFT,
  parameter int RELU_EN   = 1,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid_y,
  output logic                 s_ready_y,
  input  logic [IN_WIDTH-1:0]  s_data_in_y,
  output logic                 m_valid_z,
  input  logic                 m_ready_z,
  output logic [OUT_WIDTH-1:0] m_data_out_z,
  output logic [CNT_WIDTH-1:0] sat_cnt
);

  localparam int PW = $clog2(DEPTH);

  logic signed [RQ_W-1:0] in_ext;
  logic [RQ_W:0]          rq;
  logic [OUT_WIDTH-1:0]   rq_val;
  logic                   rq_sat;
  logic                   unused_rq_bits;
  logic [PW:0]            unused_fifo_count;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;

  logic [CNT_WIDTH-1:0]   sat_cnt_q, sat_cnt_d;

  // Requantiser on the push path: sign-extend, shift, ReLU, clip.
  assign in_ext         = RQ_W'($signed(s_data_in_y));
  assign rq             = sat_requant(in_ext, SHIFT, RELU_EN != 0, OUT_WIDTH);
  assign rq_val         = rq[OUT_WIDTH-1:0];
  assign rq_sat         = rq[RQ_W];
  assign unused_rq_bits = ^rq[RQ_W-1:OUT_WIDTH];

  assign s_ready_y = !reset && !fifo_full;
  assign push      = s_valid_y && s_ready_y;
  assign m_valid_z = !fifo_empty;
  assign pop       = m_valid_z && m_ready_z;

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (rq_val),
    .pop_i   (pop),
    .rdata_o (m_data_out_z),
    .count_o (unused_fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Saturation counter advances on accepted clipped samples and sticks at max.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (push && rq_sat && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;

endmodule
